// File: rtl/median_filter_stream.sv
// median_filter_stream
//   Streaming 3x3 median filter over a raster-order image of IMG_W x IMG_H
//   pixels. Two line buffers and a 3x3 window register supply the
//   neighbourhood. Border pixels are output as 0 or as their own input value,
//   selected by a mode bit latched at frame start.
// Ports
//   clk_i, rst_i        : clock, synchronous active-low reset
//   en_i                : enable; high starts/continues a frame, low aborts it
//   border_mode_i       : 0 = border outputs 0, 1 = border outputs input value
//   valid_i/ready_o/data_i : input pixel handshake
//   valid_o/ready_i/data_o : output pixel handshake
//   frame_done_o        : one-cycle pulse at end of frame
//   state_o             : IDLE=0 FILL=1 RUN=2 FLUSH=3 DONE=4
module median_filter_stream #(
  parameter int PIX_W = 8,
  parameter int IMG_W = 320,
  parameter int IMG_H = 240
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             border_mode_i,
  input  logic             valid_i,
  input  logic [PIX_W-1:0] data_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [PIX_W-1:0] data_o,
  input  logic             ready_i,
  output logic             frame_done_o,
  output logic [2:0]       state_o
);

  localparam int NPIX  = IMG_W * IMG_H;
  localparam int CNT_W = $clog2(NPIX);
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(IMG_W);
  localparam logic [CNT_W-1:0] PIX_LAST  = CNT_W'(NPIX - 1);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_RUN   = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                         state_q, state_d;
  logic                           mode_q, mode_d;
  logic [CNT_W-1:0]               in_cnt_q, in_cnt_d;
  logic [COL_W-1:0]               in_col_q, in_col_d;
  logic [CNT_W-1:0]               out_cnt_q, out_cnt_d;
  logic [COL_W-1:0]               out_col_q, out_col_d;
  logic [ROW_W-1:0]               out_row_q, out_row_d;
  logic                           gen_done_q, gen_done_d;
  logic                           valid_q, valid_d;
  logic [PIX_W-1:0]               data_q, data_d;
  logic [2:0][2:0][PIX_W-1:0]     win_q, win_d;   // [row top..bottom][col oldest..newest]

  logic [PIX_W-1:0] lb0_q [IMG_W];  // previous row
  logic [PIX_W-1:0] lb1_q [IMG_W];  // row before that

  logic             accept, flush_step, shift, step_out, border;
  logic [PIX_W-1:0] med;
  logic [PIX_W-1:0] pix [9];

  assign ready_o      = en_i && (state_q == S_FILL || state_q == S_RUN) && (!valid_q || ready_i);
  assign accept       = valid_i && ready_o;
  assign flush_step   = (state_q == S_FLUSH) && en_i && !gen_done_q && (!valid_q || ready_i);
  assign shift        = accept || flush_step;
  assign step_out     = (accept && state_q == S_RUN) || flush_step;
  assign border       = (out_row_q == '0) || (out_row_q == ROW_LAST) ||
                        (out_col_q == '0) || (out_col_q == COL_LAST);

  assign valid_o      = valid_q;
  assign data_o       = data_q;
  assign frame_done_o = (state_q == S_DONE);
  assign state_o      = state_q;

  // Median as the element with fewer than 5 smaller and at least 5
  // smaller-or-equal peers; any such element has the median value.
  always_comb begin
    for (int unsigned i = 0; i < 9; i++) pix[i] = win_d[i / 3][i % 3];
  end

  always_comb begin
    int unsigned lt, le;
    med = '0;
    for (int unsigned i = 0; i < 9; i++) begin
      lt = 0;
      le = 0;
      for (int unsigned j = 0; j < 9; j++) begin
        if (pix[j] <  pix[i]) lt++;
        if (pix[j] <= pix[i]) le++;
      end
      if (lt <= 4 && le >= 5) med = pix[i];
    end
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    in_cnt_d   = in_cnt_q;
    in_col_d   = in_col_q;
    out_cnt_d  = out_cnt_q;
    out_col_d  = out_col_q;
    out_row_d  = out_row_q;
    gen_done_d = gen_done_q;
    valid_d    = valid_q;
    data_d     = data_q;
    win_d      = win_q;

    // In FLUSH the window keeps shifting on each emitted output (reading the
    // last row back from lb0) so the centre tap still tracks the pixel being
    // output; the line buffers themselves change only on accepted beats.
    if (shift) begin
      for (int unsigned r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb1_q[in_col_q];
      win_d[1][2] = lb0_q[in_col_q];
      win_d[2][2] = data_i;
      in_col_d    = (in_col_q == COL_LAST) ? '0 : in_col_q + 1'b1;
    end

    if (step_out) begin
      valid_d = 1'b1;
      data_d  = border ? (mode_q ? win_d[1][1] : '0) : med;
      if (out_cnt_q == PIX_LAST) gen_done_d = 1'b1;
      else                       out_cnt_d  = out_cnt_q + 1'b1;
      if (out_col_q == COL_LAST) begin
        out_col_d = '0;
        if (out_row_q != ROW_LAST) out_row_d = out_row_q + 1'b1;
      end else begin
        out_col_d = out_col_q + 1'b1;
      end
    end else if (ready_i) begin
      valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        valid_d = 1'b0;
        if (en_i) begin
          state_d    = S_FILL;
          mode_d     = border_mode_i;
          in_cnt_d   = '0;
          in_col_d   = '0;
          out_cnt_d  = '0;
          out_col_d  = '0;
          out_row_d  = '0;
          gen_done_d = 1'b0;
        end
      end
      S_FILL: if (accept) begin
        in_cnt_d = in_cnt_q + 1'b1;
        if (in_cnt_q == FILL_LAST) state_d = S_RUN;
      end
      S_RUN: if (accept) begin
        if (in_cnt_q == PIX_LAST) state_d = S_FLUSH;
        else                      in_cnt_d = in_cnt_q + 1'b1;
      end
      S_FLUSH: if (valid_q && ready_i && gen_done_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (!en_i && state_q != S_IDLE && state_q != S_DONE) begin
      state_d    = S_IDLE;
      valid_d    = 1'b0;
      in_cnt_d   = '0;
      in_col_d   = '0;
      out_cnt_d  = '0;
      out_col_d  = '0;
      out_row_d  = '0;
      gen_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= S_IDLE;
      mode_q     <= 1'b0;
      in_cnt_q   <= '0;
      in_col_q   <= '0;
      out_cnt_q  <= '0;
      out_col_q  <= '0;
      out_row_q  <= '0;
      gen_done_q <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      win_q      <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      in_cnt_q   <= in_cnt_d;
      in_col_q   <= in_col_d;
      out_cnt_q  <= out_cnt_d;
      out_col_q  <= out_col_d;
      out_row_q  <= out_row_d;
      gen_done_q <= gen_done_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      win_q      <= win_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      lb0_q[in_col_q] <= data_i;
      lb1_q[in_col_q] <= lb0_q[in_col_q];
    end
  end

endmodule

// File: tb/tb_median_filter_stream.sv
module tb_median_filter_stream;
  localparam int W = 4;
  localparam int H = 4;
  localparam int N = W * H;

  typedef logic [7:0] img_t [N];

  logic       clk = 1'b0;
  logic       rst_i, en_i, border_mode_i, valid_i, ready_i;
  logic [7:0] data_i, data_o;
  logic       ready_o, valid_o, frame_done_o;
  logic [2:0] state_o;

  median_filter_stream #(.PIX_W(8), .IMG_W(W), .IMG_H(H)) dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .border_mode_i(border_mode_i),
    .valid_i(valid_i), .data_i(data_i), .ready_o(ready_o),
    .valid_o(valid_o), .data_o(data_o), .ready_i(ready_i),
    .frame_done_o(frame_done_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0, n_bad = 0;
  logic [7:0] exp_q [$];
  int         out_cnt = 0, fd_cnt = 0;
  int         stall_after = -1, stall_left = 0;
  bit         rand_rdy = 0;
  bit         prev_stall = 0;
  logic [7:0] prev_data = '0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Reference: border -> 0 or own value; interior -> 5th smallest of 3x3.
  function automatic void push_expected(input img_t img, input bit mode);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        if (r == 0 || r == H-1 || c == 0 || c == W-1) begin
          exp_q.push_back(mode ? img[r*W+c] : 8'd0);
        end else begin
          int q [$];
          for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
              q.push_back(int'(img[(r+dr)*W + c+dc]));
          q.sort();
          exp_q.push_back(8'(q[4]));
        end
      end
  endfunction

  // ready_i driver
  initial begin
    ready_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (stall_left > 0) begin
        ready_i = 1'b0;
        stall_left--;
      end else begin
        ready_i = rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (prev_stall) begin
        chk("hold_valid", int'(valid_o), 1);
        chk("hold_data", int'(data_o), int'(prev_data));
      end
      if (valid_o && !ready_i) chk("ready_o_stalled", int'(ready_o), 0);
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_output: got %0d, expected no output", data_o);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          chk($sformatf("pix_%0d", out_cnt), int'(data_o), int'(e));
        end
        if (out_cnt == stall_after) stall_left = 5;
        out_cnt++;
      end
      prev_stall = valid_o && !ready_i;
      prev_data  = data_o;
      if (frame_done_o) fd_cnt++;
    end
  end

  task automatic send(input img_t img, input int upto, input bit gaps);
    for (int k = 0; k < upto; k++) begin
      bit acc = 0;
      int t = 0;
      if (gaps && $urandom_range(0, 3) == 0) begin
        valid_i = 1'b0;
        @(posedge clk); #1;
      end
      valid_i = 1'b1;
      data_i  = img[k];
      while (!acc && t < 200) begin
        @(negedge clk);
        acc = ready_o;
        @(posedge clk); #1;
        t++;
      end
      valid_i = 1'b0;
      if (!acc) begin
        chk($sformatf("accept_timeout_beat_%0d", k), 0, 1);
        return;
      end
    end
  endtask

  task automatic start_frame(input bit mode, input bit flip);
    border_mode_i = mode;
    en_i = 1'b1;
    @(posedge clk); #1;
    if (flip) border_mode_i = ~mode;
  endtask

  task automatic run_frame(input img_t img, input bit mode, input bit gaps, input bit flip);
    int f0 = fd_cnt;
    int o0 = out_cnt;
    int t = 0;
    push_expected(img, mode);
    start_frame(mode, flip);
    send(img, N, gaps);
    while (fd_cnt == f0 && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    chk("frame_done_seen", fd_cnt - f0, 1);
    chk("frame_out_count", out_cnt - o0, N);
    chk("queue_empty", exp_q.size(), 0);
    exp_q.delete();
    en_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("frame_done_single", fd_cnt - f0, 1);
  endtask

  img_t ramp, flat, rnd;

  initial begin
    #1000000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      ramp[i] = 8'(i);
      flat[i] = 8'd100;
    end
    flat[1*W+1] = 8'd255;

    rst_i = 1'b0; en_i = 1'b0; border_mode_i = 1'b0;
    valid_i = 1'b0; data_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state", int'(state_o), 0);
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_data", int'(data_o), 0);
    chk("rst_ready", int'(ready_o), 0);
    chk("rst_done", int'(frame_done_o), 0);
    @(posedge clk); #1;
    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    run_frame(ramp, 1'b0, 1'b0, 1'b0);
    run_frame(ramp, 1'b1, 1'b0, 1'b0);
    run_frame(flat, 1'b1, 1'b0, 1'b0);

    stall_after = out_cnt + 6;
    run_frame(ramp, 1'b0, 1'b0, 1'b0);
    stall_after = -1;

    // Reset mid-frame after input beat 8
    push_expected(ramp, 1'b0);
    start_frame(1'b0, 1'b0);
    send(ramp, 9, 1'b0);
    rst_i = 1'b0;
    en_i  = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b1;
    @(negedge clk);
    chk("midrst_state", int'(state_o), 0);
    chk("midrst_valid", int'(valid_o), 0);
    chk("midrst_ready", int'(ready_o), 0);
    @(posedge clk); #1;
    exp_q.delete();
    run_frame(ramp, 1'b0, 1'b0, 1'b0);

    // Abort via en_i low after input beat 10, with a coincident valid beat
    begin
      int f0;
      f0 = fd_cnt;
      push_expected(ramp, 1'b0);
      start_frame(1'b0, 1'b0);
      send(ramp, 11, 1'b0);
      en_i    = 1'b0;
      valid_i = 1'b1;
      data_i  = 8'd11;
      @(negedge clk);
      chk("abort_ready", int'(ready_o), 0);
      @(posedge clk); #1;
      valid_i = 1'b0;
      @(negedge clk);
      chk("abort_state", int'(state_o), 0);
      chk("abort_valid", int'(valid_o), 0);
      repeat (4) @(posedge clk);
      #1;
      chk("abort_no_done", fd_cnt - f0, 0);
      exp_q.delete();
    end
    run_frame(ramp, 1'b0, 1'b0, 1'b0);

    // Randomized frames, random ready_i, input gaps, mode flipped mid-frame
    rand_rdy = 1;
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < N; i++) rnd[i] = 8'($urandom_range(0, 255));
      run_frame(rnd, 1'(f % 2), 1'b1, 1'b1);
    end
    run_frame(ramp, 1'b1, 1'b1, 1'b1);
    rand_rdy = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
